vga_text_mem_scroll: RTL
========================

Name: vga_text_mem_scroll

Overview:
Parametrised successor text-mode cell memory: COLS x ROWS cells of 16 bits (low byte = character, high byte = attribute). It has a byte-wide CPU port, a cell-wide read-only display port, and a hardware origin register for circular scrolling. A fill engine performs clear-screen, scroll-up-one-row and fill-row commands at one cell per cycle. It sits between the CPU bus and the VGA character generator.

Parameters:
COLS, 80, text columns
ROWS, 25, text rows
CELLS, COLS*ROWS (localparam), cell count; not required to be a power of two
SYS_AW, $clog2(2*CELLS) (localparam), CPU byte address width (12 at defaults)
VGA_AW, $clog2(CELLS) (localparam), display cell address width (11 at defaults)

Ports:
sys_clk  in  1  single clock for everything
sys_rst  in  1  synchronous, active-high reset
sys_a  in  SYS_AW  logical byte address; cell = sys_a>>1, sys_a[0]=1 selects attribute byte
sys_dw  in  8  CPU write data
sys_we  in  1  CPU write strobe
sys_dr  out  8  CPU read data, 1-cycle latency
vga_a  in  VGA_AW  logical cell address from the display
vga_dr  out  16  display cell data, 1-cycle latency
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle; accept = cmd_valid & cmd_ready
cmd_op  in  2  00 nop, 01 clear all, 10 scroll up, 11 fill row
cmd_row  in  $clog2(ROWS)  target row for fill row
cmd_fill  in  16  cell value written by the engine
done  out  1  one-cycle pulse when a command completes
origin  out  VGA_AW  current physical index of logical cell 0

Behaviour:
- Reset values: sys_dr=0, vga_dr=0, done=0, origin=0, engine IDLE. cmd_ready=0 while sys_rst is high, 1 afterwards. RAM contents are not cleared by reset.
- Address translation for both ports: phys = log + origin; if phys >= CELLS then phys -= CELLS. Logical addresses >= CELLS are undefined: writes are dropped, reads return 0.
- CPU write: byte lane sys_a[0] of cell phys is updated at the clock edge. The same-cycle read returns the new data (write-first).
- Display port: vga_dr = mem[phys(vga_a)] one cycle after vga_a is presented. A cycle where a write hits the same cell returns the new data.
- Engine FSM:
  - IDLE: on accept, latch cmd_fill, start index and count, then go to FILL. nop pulses done on the next cycle with no writes.
  - FILL: writes the full 16-bit cmd_fill to the current physical cell each cycle; the index wraps CELLS-1 -> 0. After count writes, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - cmd_ready=1 only in IDLE.
- Commands:
  - clear all: start = phys 0, count = CELLS. origin is reset to 0 at accept.
  - scroll up: at accept, origin <= (origin+COLS) wrap CELLS. The fill starts at the old origin with count = COLS; this row becomes logical row ROWS-1. The display may show the stale row for COLS cycles, which is accepted.
  - fill row: start = phys(cmd_row*COLS), count = COLS. If cmd_row >= ROWS, no writes occur and done pulses next cycle.
- Latency: accept at cycle 0; writes occur on cycles 1..count; done is high on cycle count+1; cmd_ready returns to 1 on cycle count+2.
- While busy:
  - The engine owns the CPU port. sys_we is ignored and sys_dr returns 0.
  - The display port keeps operating.
  - cmd_valid is held off by cmd_ready=0.
- Same cycle as accept: a concurrent sys_we is performed using the old origin.
- Reset mid-command: engine returns to IDLE, no done pulse, origin=0. Cells already written keep their fill value; the rest are unchanged.

Decomposition:
- Package vga_text_pkg:
  - op code constants CMD_NOP, CMD_CLEAR, CMD_SCROLL, CMD_FILL
  - default COLS/ROWS
  - FSM state typedef {IDLE, FILL, DONE}
  - cell struct {attr[7:0], chr[7:0]}
- Sub-module vga_text_dpram: inferred true dual-port RAM, CELLS x 16.
  - Port A: read/write, per-byte write enables, write-first.
  - Port B: read-only, synchronous reset of its output register.
- Top level holds address translation, origin and FSM; the engine and the CPU are muxed onto port A.

Test Plan:
1. Reset; write 0x41 to byte 0 and 0x07 to byte 1; vga_a=0 -> vga_dr=0x0741 the next cycle; sys_a=1 read -> sys_dr=0x07.
2. clear all with fill 0x0720 -> cmd_ready low, 2000 writes, done pulse on cycle 2001; vga_a=0 and vga_a=1999 read 0x0720.
3. Write 0x0741 at cell 80, then scroll up with fill 0x0000 -> origin=80; vga_a=0 reads 0x0741; vga_a=1920..1999 read 0x0000.
4. 25 consecutive scrolls -> origin steps 80,160,...,1920, then 0; the contents of logical row 0 are checked after each step.
5. sys_we during busy -> the cell is unchanged; fill row with cmd_row=25 -> no writes, done pulses on cycle 1.
6. sys_rst asserted 100 cycles into clear all -> done never pulses, origin=0, cells 0..99 hold the fill value, cell 100 is unchanged, cmd_ready=1 after reset.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared types and constants for the scrolling text-mode cell memory.
package vga_text_pkg;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 25;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_CLEAR  = 2'b01;
    localparam logic [1:0] CMD_SCROLL = 2'b10;
    localparam logic [1:0] CMD_FILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } eng_state_t;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } cell_t;

endpackage

// File: rtl/vga_text_dpram.sv
// CELLS x 16 dual-port RAM: port A byte-write read/write (write-first), port B read-only.
// One-cycle read latency on both ports; port B returns port A's new data on an address collision.
module vga_text_dpram #(
    parameter int DEPTH = 2000,
    parameter int AW    = 11
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_a_addr,
    input  logic [1:0]    i_a_we,
    input  logic [15:0]   i_a_din,
    output logic [15:0]   o_a_dout,
    input  logic [AW-1:0] i_b_addr,
    output logic [15:0]   o_b_dout
);

    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_a_dout;
    logic [15:0] r_b_dout;
    logic [15:0] w_a_new;

    always_comb begin
        w_a_new = r_mem[i_a_addr];
        if (i_a_we[0]) w_a_new[7:0]  = i_a_din[7:0];
        if (i_a_we[1]) w_a_new[15:8] = i_a_din[15:8];
    end

    always_ff @(posedge i_clk) begin
        if (i_a_we[0]) r_mem[i_a_addr][7:0]  <= i_a_din[7:0];
        if (i_a_we[1]) r_mem[i_a_addr][15:8] <= i_a_din[15:8];
        r_a_dout <= w_a_new;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_b_dout <= '0;
        else if ((i_a_we != 2'b00) && (i_a_addr == i_b_addr))
            r_b_dout <= w_a_new;
        else
            r_b_dout <= r_mem[i_b_addr];
    end

    assign o_a_dout = r_a_dout;
    assign o_b_dout = r_b_dout;

endmodule

// File: rtl/vga_text_mem_scroll.sv
// Text cell memory with circular-scroll origin and a one-cell-per-cycle fill engine.
// Reads return one cycle later; while the engine runs it owns the CPU port and holds cmd_ready low.
module vga_text_mem_scroll
    import vga_text_pkg::*;
#(
    parameter  int COLS   = DEF_COLS,
    parameter  int ROWS   = DEF_ROWS,
    localparam int CELLS  = COLS * ROWS,
    localparam int SYS_AW = $clog2(2 * CELLS),
    localparam int VGA_AW = $clog2(CELLS),
    localparam int ROW_W  = $clog2(ROWS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [SYS_AW-1:0] sys_a,
    input  logic [7:0]        sys_dw,
    input  logic              sys_we,
    output logic [7:0]        sys_dr,
    input  logic [VGA_AW-1:0] vga_a,
    output logic [15:0]       vga_dr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic [15:0]       cmd_fill,
    output logic              done,
    output logic [VGA_AW-1:0] origin
);

    localparam logic [VGA_AW:0]   L_CELLS  = (VGA_AW + 1)'(CELLS);
    localparam logic [VGA_AW:0]   L_COLS_N = (VGA_AW + 1)'(COLS);
    localparam logic [VGA_AW-1:0] L_COLS   = VGA_AW'(COLS);
    localparam logic [ROW_W:0]    L_ROWS   = (ROW_W + 1)'(ROWS);
    localparam logic [VGA_AW:0]   L_ONE    = (VGA_AW + 1)'(1);

    // Logical -> physical: both operands are below CELLS, so one conditional subtract wraps.
    function automatic logic [VGA_AW-1:0] f_phys(input logic [VGA_AW-1:0] i_log,
                                                 input logic [VGA_AW-1:0] i_org);
        logic [VGA_AW:0] v_sum;
        v_sum = {1'b0, i_log} + {1'b0, i_org};
        if (v_sum >= L_CELLS) v_sum = v_sum - L_CELLS;
        return v_sum[VGA_AW-1:0];
    endfunction

    eng_state_t        r_state;
    eng_state_t        w_state_nxt;
    logic [VGA_AW-1:0] r_origin;
    logic [VGA_AW-1:0] r_idx;
    logic [VGA_AW:0]   r_cnt;
    cell_t             r_fill;
    logic              r_sys_ok;
    logic              r_sys_hi;
    logic              r_vga_ok;

    logic              w_idle;
    logic              w_accept;
    logic [VGA_AW-1:0] w_sys_cell;
    logic              w_sys_in;
    logic              w_vga_in;
    logic              w_row_ok;
    logic [VGA_AW-1:0] w_row_base;
    logic [VGA_AW-1:0] w_a_addr;
    logic [1:0]        w_a_we;
    cell_t             w_a_din;
    logic [15:0]       w_a_dout;
    logic [15:0]       w_b_dout;

    assign w_idle     = (r_state == IDLE);
    assign cmd_ready  = w_idle & ~sys_rst;
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_sys_cell = sys_a[SYS_AW-1:1];
    assign w_sys_in   = ({1'b0, w_sys_cell} < L_CELLS);
    assign w_vga_in   = ({1'b0, vga_a} < L_CELLS);
    assign w_row_ok   = ({1'b0, cmd_row} < L_ROWS);
    assign w_row_base = VGA_AW'(cmd_row) * L_COLS;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if ((cmd_op == CMD_NOP) || ((cmd_op == CMD_FILL) && !w_row_ok))
                        w_state_nxt = DONE;
                    else
                        w_state_nxt = FILL;
                end
            end
            FILL:    if (r_cnt == L_ONE) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_origin <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_fill   <= '0;
        end else if (w_accept) begin
            r_fill <= cmd_fill;
            case (cmd_op)
                CMD_CLEAR: begin
                    r_idx    <= '0;
                    r_cnt    <= L_CELLS;
                    r_origin <= '0;
                end
                CMD_SCROLL: begin
                    // The departing top row becomes the new bottom row.
                    r_idx    <= r_origin;
                    r_cnt    <= L_COLS_N;
                    r_origin <= f_phys(L_COLS, r_origin);
                end
                CMD_FILL: begin
                    r_idx <= f_phys(w_row_base, r_origin);
                    r_cnt <= L_COLS_N;
                end
                default: ;
            endcase
        end else if (r_state == FILL) begin
            r_idx <= ({1'b0, r_idx} == (L_CELLS - L_ONE)) ? '0 : r_idx + 1'b1;
            r_cnt <= r_cnt - L_ONE;
        end
    end

    always_comb begin
        w_a_addr     = f_phys(w_sys_cell, r_origin);
        w_a_we       = 2'b00;
        w_a_din.attr = sys_dw;
        w_a_din.chr  = sys_dw;
        if (!sys_rst) begin
            if (r_state == FILL) begin
                w_a_addr = r_idx;
                w_a_we   = 2'b11;
                w_a_din  = r_fill;
            end else if (w_idle && sys_we && w_sys_in) begin
                w_a_we = sys_a[0] ? 2'b10 : 2'b01;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sys_ok <= 1'b0;
            r_sys_hi <= 1'b0;
            r_vga_ok <= 1'b0;
        end else begin
            r_sys_ok <= w_idle & w_sys_in;
            r_sys_hi <= sys_a[0];
            r_vga_ok <= w_vga_in;
        end
    end

    vga_text_dpram #(
        .DEPTH (CELLS),
        .AW    (VGA_AW)
    ) u_ram (
        .i_clk    (sys_clk),
        .i_rst    (sys_rst),
        .i_a_addr (w_a_addr),
        .i_a_we   (w_a_we),
        .i_a_din  (w_a_din),
        .o_a_dout (w_a_dout),
        .i_b_addr (f_phys(vga_a, r_origin)),
        .o_b_dout (w_b_dout)
    );

    assign sys_dr = !r_sys_ok ? 8'h00 : (r_sys_hi ? w_a_dout[15:8] : w_a_dout[7:0]);
    assign vga_dr = r_vga_ok ? w_b_dout : 16'h0000;
    assign done   = (r_state == DONE);
    assign origin = r_origin;

endmodule
